// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one i2c master among four requesters.
// A winner's request fields are captured at grant time and held steady on the
// master-side outputs until the response cycle, whatever the requesters do.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort transactions that stay
// in the wait states for TIMEOUT_CYCLES clocks; without it the block waits
// indefinitely and timeout_err is tied low.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [27:0] req_addr,
  input  logic [3:0]  req_rw,
  input  logic [3:0]  req_two_bytes,
  input  logic [63:0] req_wdata,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [15:0] rd_data,
  output logic        ack_ok,
  output logic        timeout_err,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic        m_two_bytes,
  output logic [15:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_ack,
  input  logic [15:0] m_rdata
);

  localparam int NUM_REQ = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic        two;
    logic [15:0] wdata;
  } req_t;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  own_q;
  logic [3:0]  grant_q;
  logic [3:0]  done_q;
  logic [15:0] rd_q;
  logic        ack_q;
  logic        start_q;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic        two_q;
  logic [15:0] wdata_q;
  logic        to_hit;

  req_t [NUM_REQ-1:0] rq;

  // Split the flat request buses into one record per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rq[gi] = {req_addr[7*gi +: 7], req_rw[gi], req_two_bytes[gi],
                     req_wdata[16*gi +: 16]};
  end

  logic [1:0] win_d;

  // Round-robin pick: first asserted request at or after the pointer.
  always_comb begin
    win_d = ptr_q;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) win_d = ptr_q + 2'(k);
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = 20;
  logic [CW-1:0] cnt_q;
  logic          to_q;

  assign to_hit      = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_q;

  // Watchdog: counts cycles spent waiting on the master, restarts per issue.
  always_ff @(posedge clk) begin
    if (rst)                                              cnt_q <= '0;
    else if (state_q == ISSUE)                            cnt_q <= '0;
    else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      two_q   <= 1'b0;
      wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if ((|req) && m_ready) begin
            own_q   <= win_d;
            grant_q <= 4'(1) << win_d;
            addr_q  <= rq[win_d].addr;
            rw_q    <= rq[win_d].rw;
            two_q   <= rq[win_d].two;
            wdata_q <= rq[win_d].wdata;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          // A master that never goes busy is caught by the watchdog here.
          if (to_hit) begin
            rd_q    <= '0;
            ack_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            to_q    <= 1'b1;
`endif
            done_q  <= grant_q;
            state_q <= RESPOND;
          end else if (!m_ready) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A finished transfer wins over a watchdog expiring the same cycle.
          if (m_ready) begin
            rd_q    <= rw_q ? m_rdata : 16'h0;
            ack_q   <= m_ack;
`ifdef I2C_ARB_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
            done_q  <= grant_q;
            state_q <= RESPOND;
          end else if (to_hit) begin
            rd_q    <= '0;
            ack_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            to_q    <= 1'b1;
`endif
            done_q  <= grant_q;
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          grant_q <= '0;
          addr_q  <= '0;
          rw_q    <= 1'b0;
          two_q   <= 1'b0;
          wdata_q <= '0;
          ptr_q   <= own_q + 2'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign rd_data     = rd_q;
  assign ack_ok      = ack_q;
  assign m_start     = start_q;
  assign m_addr      = addr_q;
  assign m_rw        = rw_q;
  assign m_two_bytes = two_q;
  assign m_wdata     = wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: transaction-level reference model checked
// every cycle, a behavioural i2c master, directed scenarios and random traffic.
module tb_i2c_arbiter;

  localparam int TO = 10;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [3:0]  req_two_bytes;
  logic [63:0] req_wdata;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [15:0] rd_data;
  logic        ack_ok;
  logic        timeout_err;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic        m_two_bytes;
  logic [15:0] m_wdata;
  logic        m_ready;
  logic        m_ack;
  logic [15:0] m_rdata;

  i2c_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_two_bytes(req_two_bytes), .req_wdata(req_wdata), .grant(grant),
    .done(done), .rd_data(rd_data), .ack_ok(ack_ok), .timeout_err(timeout_err),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_two_bytes(m_two_bytes),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: who owns the master, whether this is the start cycle,
  // whether the master has gone busy yet, and whether this is the reply cycle.
  bit          chk_on = 1'b0;
  int          own = -1;
  int          ptr = 0;
  bit          start_now = 1'b0, resp_now = 1'b0, busy_seen = 1'b0;
  int          waitn = 0;
  logic [6:0]  e_addr = '0;
  logic        e_rw = 1'b0, e_two = 1'b0;
  logic [15:0] e_wdata = '0;
  logic [15:0] e_rd = '0;
  logic        e_ack = 1'b0, e_to = 1'b0;
  int          waitcnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant",   32'(grant),       (own >= 0) ? 32'(1 << own) : 32'd0);
      chk("done",    32'(done),        resp_now ? 32'(1 << own) : 32'd0);
      chk("m_start", 32'(m_start),     32'(start_now));
      chk("m_addr",  32'(m_addr),      (own >= 0) ? 32'(e_addr) : 32'd0);
      chk("m_rw",    32'(m_rw),        (own >= 0) ? 32'(e_rw) : 32'd0);
      chk("m_two",   32'(m_two_bytes), (own >= 0) ? 32'(e_two) : 32'd0);
      chk("m_wdata", 32'(m_wdata),     (own >= 0) ? 32'(e_wdata) : 32'd0);
      chk("rd_data", 32'(rd_data),     32'(e_rd));
      chk("ack_ok",  32'(ack_ok),      32'(e_ack));
      chk("timeout", 32'(timeout_err), 32'(e_to));
    end
    if (rst) begin
      own = -1; ptr = 0; start_now = 0; resp_now = 0; busy_seen = 0;
      e_rd = '0; e_ack = 0; e_to = 0;
      for (int j = 0; j < 4; j++) waitcnt[j] = 0;
    end else if (resp_now) begin
      ptr = (own + 1) % 4; own = -1; resp_now = 0;
    end else if (own < 0) begin
      if (req != 4'd0 && m_ready) begin
        for (int k = 3; k >= 0; k--) if (req[(ptr + k) % 4]) own = (ptr + k) % 4;
        e_addr  = req_addr[7*own +: 7];
        e_rw    = req_rw[own];
        e_two   = req_two_bytes[own];
        e_wdata = req_wdata[16*own +: 16];
        start_now = 1;
        if (chk_on) chk("fair", 32'(waitcnt[own] <= 3), 32'd1);
        for (int j = 0; j < 4; j++)
          if (j == own) waitcnt[j] = 0;
          else if (req[j]) waitcnt[j]++;
          else waitcnt[j] = 0;
      end
    end else if (start_now) begin
      start_now = 0; busy_seen = 0; waitn = 0;
    end else begin
      waitn++;
      if (busy_seen && m_ready) begin
        e_rd = e_rw ? m_rdata : 16'h0; e_ack = m_ack; e_to = 0; resp_now = 1;
      end else if (TIMEOUT_ON && waitn == TO) begin
        e_rd = '0; e_ack = 0; e_to = 1; resp_now = 1;
      end else if (!m_ready) begin
        busy_seen = 1;
      end
    end
  end

  // ---------------- behavioural i2c master ----------------
  bit          m_stuck = 1'b0, use_fix = 1'b0;
  logic [15:0] fix_rdata = '0;
  logic        fix_ack = 1'b1;
  int          fix_busy = 0;
  int          lat, bsy;

  initial begin
    m_ready = 1'b1; m_ack = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && !m_stuck) begin
        lat = $urandom_range(0, 2);
        bsy = (fix_busy > 0) ? fix_busy : $urandom_range(1, 4);
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #1 m_ready = 1'b0; m_rdata = 16'($urandom); m_ack = 1'($urandom);
        repeat (bsy) @(posedge clk);
        #1 m_ready = 1'b1;
        m_ack   = use_fix ? fix_ack : 1'($urandom);
        m_rdata = use_fix ? fix_rdata : 16'($urandom);
      end
    end
  end

  logic [3:0] dseen = '0;
  always @(negedge clk) dseen = done;

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiesce();
    req = '0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (grant == 4'd0 && m_ready && dut.m_start == 1'b0) begin
        tick(); return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL quiesce: arbiter/master never returned idle");
  endtask

  task automatic wait_txn(output logic [3:0] g, output logic [6:0] a, output int nst,
                          output int st_c, output int dn_c, output logic [3:0] d);
    g = '0; a = '0; nst = 0; st_c = 0; dn_c = 0; d = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_start) begin nst++; g = grant; a = m_addr; st_c = c; end
      if (done != 4'd0) begin d = done; dn_c = c; return; end
    end
    vectors++; miscompares++;
    $display("FAIL txn_wait: no done within 200 cycles");
  endtask

  logic [3:0] g, d;
  logic [6:0] a;
  int         nst, st_c, dn_c;
  bit         hit;
  logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_two_bytes = '0; req_wdata = '0;
    @(posedge clk); #1 chk_on = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_rd",    32'(rd_data), 32'd0);
    tick(); rst = 1'b0;
    tick();

    // single two-byte read from requester 2
    req_addr[20:14] = 7'h48; req_rw = 4'b0100; req_two_bytes = 4'b0100;
    use_fix = 1; fix_rdata = 16'h1980; fix_ack = 1'b1;
    req = 4'b0100;
    wait_txn(g, a, nst, st_c, dn_c, d);
    chk("rd_grant", 32'(g), 32'h4);
    chk("rd_addr",  32'(a), 32'h48);
    chk("rd_nst",   32'(nst), 32'd1);
    chk("rd_done",  32'(d), 32'h4);
    chk("rd_data",  32'(rd_data), 32'h1980);
    chk("rd_ack",   32'(ack_ok), 32'd1);
    tick(); req = '0;
    @(negedge clk);
    chk("rd_done_1cyc", 32'(done), 32'd0);
    quiesce();

    // write with NACK: read data must be masked, ack low, no timeout
    req_rw = '0; fix_ack = 1'b0; fix_rdata = 16'hBEEF;
    req = 4'b0001;
    wait_txn(g, a, nst, st_c, dn_c, d);
    chk("nack_done", 32'(d), 32'h1);
    chk("nack_ack",  32'(ack_ok), 32'd0);
    chk("nack_to",   32'(timeout_err), 32'd0);
    chk("nack_rd",   32'(rd_data), 32'd0);
    quiesce();

    // contention from a fresh pointer
    use_fix = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_txn(g, a, nst, st_c, dn_c, d);
      chk("rr_grant", 32'(g), 32'(exp_seq[k]));
      chk("rr_nst",   32'(nst), 32'd1);
    end
    quiesce();

    // captured address survives toggling of the requester's address
    req_addr = '0; req_addr[6:0] = 7'h11; fix_busy = 6;
    req = 4'b0001; hit = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done != 4'd0) begin hit = 1; break; end
      if (grant == 4'b0001 && !m_ready) req_addr[6:0] = ~req_addr[6:0];
    end
    chk("stab_seen", 32'(hit), 32'd1);
    chk("stab_done", 32'(done), 32'h1);
    chk("stab_addr", 32'(m_addr), 32'h11);
    quiesce();

    // reset in the middle of a transfer
    req = 4'b0010; hit = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (grant != 4'd0 && !m_ready) begin hit = 1; break; end
    end
    chk("rm_reach", 32'(hit), 32'd1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b1000;
    @(negedge clk);
    chk("rm_grant", 32'(grant), 32'd0);
    chk("rm_start", 32'(m_start), 32'd0);
    chk("rm_done",  32'(done), 32'd0);
    wait_txn(g, a, nst, st_c, dn_c, d);
    chk("rm_next",  32'(g), 32'h8);
    chk("rm_ndone", 32'(d), 32'h8);
    quiesce();
    fix_busy = 0;

`ifdef I2C_ARB_TIMEOUT_EN
    // master never goes busy: watchdog aborts
    m_stuck = 1; req = 4'b0001;
    wait_txn(g, a, nst, st_c, dn_c, d);
    chk("to_lat",  32'(dn_c - st_c), 32'd11);
    chk("to_err",  32'(timeout_err), 32'd1);
    chk("to_rd",   32'(rd_data), 32'd0);
    chk("to_ack",  32'(ack_ok), 32'd0);
    quiesce();
    m_stuck = 0;
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_addr = 28'($urandom); req_rw = 4'($urandom);
      req_two_bytes = 4'($urandom); req_wdata = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end else if (dseen[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    quiesce();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning the watchdog limit in clk cycles per transaction; it is legal range 2..2^20-1.
REQ-002 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-003 It SHALL have the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  4  per-requester transaction request, held until done
- req_addr  in  28  4x7-bit slave address; requester i uses bits [7i+6:7i]
- req_rw  in  4  per-requester direction: 0 = write, 1 = read
- req_two_bytes  in  4  per-requester length: 1 = two bytes, 0 = one byte
- req_wdata  in  64  4x16-bit write data; requester i uses bits [16i+15:16i]
- grant  out  4  one-hot owner of the master, zero when idle
- done  out  4  one-cycle completion pulse to the owner
- rd_data  out  16  read data of the last completed transaction
- ack_ok  out  1  slave acknowledged the last completed transaction
- timeout_err  out  1  last completed transaction was aborted by the watchdog
- m_start  out  1  one-cycle start pulse to the i2c master
- m_addr  out  7  slave address to the master
- m_rw  out  1  direction to the master
- m_two_bytes  out  1  length to the master
- m_wdata  out  16  write data to the master
- m_ready  in  1  master idle/finished
- m_ack  in  1  master got_acknowledge
- m_rdata  in  16  master read_data

Function
REQ-004 The block SHALL implement the FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESPOND.
REQ-005 IDLE: if any req bit is 1 and m_ready=1, the block SHALL select winner g by round-robin starting at pointer ptr (ptr, ptr+1, ... mod 4), register grant=1<<g and m_addr/m_rw/m_two_bytes/m_wdata from requester g, and go to ISSUE; otherwise it stays in IDLE.
REQ-006 ISSUE: the block SHALL assert m_start=1 for exactly this one cycle and then go to WAIT_BUSY.
REQ-007 WAIT_BUSY: on m_ready=0 the block SHALL go to WAIT_DONE; on m_ready=1 it stays in WAIT_BUSY, which covers the master's start latency.
REQ-008 WAIT_DONE: on m_ready=1 the block SHALL latch rd_data=m_rdata (0 if m_rw=0), ack_ok=m_ack and timeout_err=0, then go to RESPOND.
REQ-009 RESPOND: the block SHALL drive done[g]=1 for one cycle, clear grant and the m_* fields to 0, set ptr=(g+1) mod 4, and go to IDLE.
REQ-010 Total arbitration overhead SHALL be 2 cycles before the master starts plus 1 cycle after it finishes; a new grant is possible the cycle after RESPOND.
REQ-011 The m_* outputs and grant SHALL remain stable from ISSUE through RESPOND regardless of changes on the req_* inputs.
REQ-012 If the owner drops req mid-transaction, the transaction SHALL complete normally and done still pulses.
REQ-013 A requester that keeps req high after done SHALL be treated as a new request and arbitrated fairly; no requester waits more than 3 other transactions.
REQ-014 Simultaneous requests SHALL be granted in round-robin order; for example, with ptr=0 and req=4'b1111 the grant order is 0, 1, 2, 3, 0.
REQ-015 rd_data, ack_ok and timeout_err SHALL hold their values until the next RESPOND.

Reset
REQ-016 While rst=1 at a clk edge the block SHALL set state=IDLE, ptr=0, and grant, done, rd_data, ack_ok, timeout_err, m_start, m_addr, m_rw, m_two_bytes and m_wdata all to 0.
REQ-017 Reset asserted mid-transaction SHALL abort without a done pulse; after reset, arbitration waits for m_ready=1.

Configuration
REQ-018 With I2C_ARB_TIMEOUT_EN defined, the block SHALL count cycles spent in WAIT_BUSY+WAIT_DONE; on reaching TIMEOUT_CYCLES it goes to RESPOND with rd_data=0, ack_ok=0 and timeout_err=1, and the counter clears on entry to ISSUE.
REQ-019 With I2C_ARB_TIMEOUT_EN undefined, the block SHALL have no counter, SHALL wait indefinitely, and SHALL tie timeout_err to 0.

Verification
REQ-020 Single read: req=4'b0100, addr 7'h48, rw=1, two_bytes=1, master returns 16'h1980 with ack -> m_start pulses once with m_addr=7'h48; done=4'b0100 for 1 cycle; rd_data=16'h1980; ack_ok=1.
REQ-021 Contention: req=4'b1111 held continuously, ptr=0 -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one m_start per grant.
REQ-022 NACK: master returns m_ack=0 -> done pulses; ack_ok=0; timeout_err=0.
REQ-023 Timeout (macro on, TIMEOUT_CYCLES=10): m_ready held 1 after m_start -> done pulses 10 cycles after leaving ISSUE; timeout_err=1; rd_data=0.
REQ-024 Reset mid-op: assert rst during WAIT_DONE -> next cycle grant=0, m_start=0, done=0; a subsequent req=4'b1000 is granted first since ptr=0 and it is the only request.
REQ-025 Input stability: toggle req_addr[6:0] during WAIT_DONE for owner 0 -> m_addr remains unchanged until RESPOND.
